// File: rtl/vga_pkg.sv
// Shared VGA constants, payload types and helpers for the raster generator and renderers.
// Optional build macro TEST_PATTERN_EN adds a delayed column field to the sync payload.
package vga_pkg;

  // Picture size the renderers are built around
  localparam int unsigned WINDOW_WIDTH  = 640;
  localparam int unsigned WINDOW_HEIGHT = 480;

  // 640x480@60 timing defaults
  localparam int unsigned H_ACTIVE_DEF = WINDOW_WIDTH;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = WINDOW_HEIGHT;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Datapath widths
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CMP_W   = 11;
  localparam int unsigned FRAME_W = 16;

  // Full period of one axis: visible + front porch + sync + back porch
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Merged renderer colour, {R,G,B}
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Per-pixel timing payload carried through the renderer-latency pipeline
`ifdef TEST_PATTERN_EN
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vld;
    logic [CNT_W-1:0] col;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, vld: 1'b0, col: '0};
`else
  typedef struct packed {
    logic hs;
    logic vs;
    logic vld;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, vld: 1'b0};
`endif

  // Colour of test bar k: each index bit switches one primary fully on
  function automatic rgb_t bar_color(input logic [2:0] k);
    rgb_t c;
    c.r = {COLOR_W{k[2]}};
    c.g = {COLOR_W{k[1]}};
    c.b = {COLOR_W{k[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/video bundle between the timing generator, the renderers and the connector.
// Optional build macro TEST_PATTERN_EN adds the test_mode input.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [RGB_W-1:0]   rgb_in;
  logic               pix_en;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               valid;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] vgaRed;
  logic [COLOR_W-1:0] vgaGreen;
  logic [COLOR_W-1:0] vgaBlue;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_cnt;
`ifdef TEST_PATTERN_EN
  logic               test_mode;

  modport master (
    input  rgb_in, test_mode,
    output pix_en, h_cnt, v_cnt, valid, hsync, vsync,
           vgaRed, vgaGreen, vgaBlue, frame_tick, frame_cnt
  );

  modport slave (
    output rgb_in, test_mode,
    input  pix_en, h_cnt, v_cnt, valid, hsync, vsync,
           vgaRed, vgaGreen, vgaBlue, frame_tick, frame_cnt
  );
`else
  modport master (
    input  rgb_in,
    output pix_en, h_cnt, v_cnt, valid, hsync, vsync,
           vgaRed, vgaGreen, vgaBlue, frame_tick, frame_cnt
  );

  modport slave (
    output rgb_in,
    input  pix_en, h_cnt, v_cnt, valid, hsync, vsync,
           vgaRed, vgaGreen, vgaBlue, frame_tick, frame_cnt
  );
`endif

endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages; output is the oldest stage.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  // Shift one stage per enable; all stages return to RST_VAL on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel divider, h/v counters, renderer-latency compensation
// for sync/blanking, blanked RGB output registers and frame tick/counter.
// Optional build macro TEST_PATTERN_EN adds test_mode, which replaces rgb_in with
// eight vertical colour bars of width H_ACTIVE/8.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned PIPE_DELAY = 2
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = 4;
  localparam int unsigned SYNC_W   = $bits(sync_t);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  // Registered state
  logic [DIV_W-1:0]   div_q;
  logic               pix_en_q;
  logic [CNT_W-1:0]   h_q;
  logic [CNT_W-1:0]   v_q;
  logic               valid_q;
  logic               frame_tick_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  rgb_t               rgb_q;

  // Combinational helpers
  logic [DIV_W-1:0]   div_nxt_c;
  logic [CMP_W-1:0]   h_ext_c;
  logic [CMP_W-1:0]   v_ext_c;
  logic               h_wrap_c;
  logic               v_wrap_c;
  logic               frame_wrap_c;
  logic [CNT_W-1:0]   h_nxt_c;
  logic [CNT_W-1:0]   v_nxt_c;
  sync_t              sync_in_c;
  rgb_t               pix_src_c;

  logic [SYNC_W-1:0]  sync_out_vec;
  sync_t              sync_out;

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // Bar index of a visible column; boundaries sit at multiples of H_ACTIVE/8
  function automatic logic [2:0] bar_of(input logic [CNT_W-1:0] col);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (CMP_W'(col) >= CMP_W'(k * BAR_W)) begin
        idx = 3'(k);
      end
    end
    return idx;
  endfunction
`endif

  // Pixel divider next value; wraps after PIX_DIV-1
  always_comb begin
    div_nxt_c = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_nxt_c = '0;
    end
  end

  // Divider register; pix_en is pre-decoded so it is high exactly while div == PIX_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_nxt_c;
      pix_en_q <= (div_nxt_c == DIV_LAST);
    end
  end

  // Raster next-position and wrap decode (11-bit compares)
  always_comb begin
    h_ext_c      = CMP_W'(h_q);
    v_ext_c      = CMP_W'(v_q);
    h_wrap_c     = (h_ext_c == CMP_W'(H_TOTAL - 1));
    v_wrap_c     = (v_ext_c == CMP_W'(V_TOTAL - 1));
    frame_wrap_c = pix_en_q && h_wrap_c && v_wrap_c;
    h_nxt_c      = h_q;
    v_nxt_c      = v_q;
    if (pix_en_q) begin
      h_nxt_c = h_wrap_c ? '0 : h_q + CNT_W'(1);
      if (h_wrap_c) begin
        v_nxt_c = v_wrap_c ? '0 : v_q + CNT_W'(1);
      end
    end
  end

  // Raster counters, undelayed valid (decoded from the next position) and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q          <= '0;
      v_q          <= '0;
      valid_q      <= 1'b1;  // (0,0) is a visible pixel
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      h_q          <= h_nxt_c;
      v_q          <= v_nxt_c;
      valid_q      <= (CMP_W'(h_nxt_c) < CMP_W'(H_ACTIVE)) && (CMP_W'(v_nxt_c) < CMP_W'(V_ACTIVE));
      frame_tick_q <= frame_wrap_c;
      frame_cnt_q  <= frame_cnt_q + FRAME_W'(frame_wrap_c);
    end
  end

  // Raw active-low syncs and visibility of the current position
  always_comb begin
    sync_in_c     = SYNC_RST;
    sync_in_c.hs  = !((h_ext_c >= CMP_W'(HS_START)) && (h_ext_c < CMP_W'(HS_END)));
    sync_in_c.vs  = !((v_ext_c >= CMP_W'(VS_START)) && (v_ext_c < CMP_W'(VS_END)));
    sync_in_c.vld = (h_ext_c < CMP_W'(H_ACTIVE)) && (v_ext_c < CMP_W'(V_ACTIVE));
`ifdef TEST_PATTERN_EN
    sync_in_c.col = h_q;
`endif
  end

  // Delay sync/blanking by the renderers' read latency, one stage per pixel step
  vga_delay_line #(
    .WIDTH   (SYNC_W),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_RST)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en_q),
    .din  (sync_in_c),
    .dout (sync_out_vec)
  );

  assign sync_out = sync_t'(sync_out_vec);

  // Colour source for the pixel whose delayed timing is at the pipeline output
  always_comb begin
    pix_src_c = rgb_t'(bus.rgb_in);
`ifdef TEST_PATTERN_EN
    if (bus.test_mode) begin
      pix_src_c = bar_color(bar_of(sync_out.col));
    end
`endif
  end

  // RGB output registers: sample on pixel strobe, force black outside the visible area
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (pix_en_q) begin
      rgb_q <= sync_out.vld ? pix_src_c : '0;
    end
  end

  assign bus.pix_en     = pix_en_q;
  assign bus.h_cnt      = h_q;
  assign bus.v_cnt      = v_q;
  assign bus.valid      = valid_q;
  assign bus.hsync      = sync_out.hs;
  assign bus.vsync      = sync_out.vs;
  assign bus.vgaRed     = rgb_q.r;
  assign bus.vgaGreen   = rgb_q.g;
  assign bus.vgaBlue    = rgb_q.b;
  assign bus.frame_tick = frame_tick_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
